// File: rtl/led_div_seq.sv
// led_div_seq: steps an led_cnt divider through a programmable table of
// blink rates. Each entry holds a divider value and a dwell in ticks.
// Entries with a zero dwell are skipped. A pass either stops after the
// last entry or wraps around to entry 0.
module led_div_seq #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1000,
    parameter int NSTEP   = 4,
    parameter int DIV_W   = 5,
    parameter int DWELL_W = 16,
    localparam int IW     = $clog2(NSTEP)
) (
    input  logic               clk100,
    input  logic               rst,
    input  logic               en_i,
    input  logic               oneshot_i,
    input  logic               cfg_we_i,
    input  logic [IW-1:0]      cfg_idx_i,
    input  logic [DIV_W-1:0]   cfg_div_i,
    input  logic [DWELL_W-1:0] cfg_dwell_i,
    output logic [DIV_W-1:0]   div_o,
    output logic               wren_o,
    output logic [IW-1:0]      step_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int P  = CLK_HZ / TICK_HZ;
    localparam int PW = (P > 1) ? $clog2(P) : 1;
    localparam int SW = IW + 1;
    localparam logic [PW-1:0]      P_LAST    = PW'(P - 1);
    localparam logic [IW-1:0]      IDX_LAST  = IW'(NSTEP - 1);
    localparam logic [SW-1:0]      SKIP_ALL  = SW'(NSTEP);
    localparam logic [DWELL_W-1:0] DWELL_RST = DWELL_W'(500);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DWELL = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    // Table read view: one entry per element, registers live in g_tab.
    logic [DIV_W-1:0]   w_tab_div   [NSTEP];
    logic [DWELL_W-1:0] w_tab_dwell [NSTEP];

    genvar gi;
    generate
        for (gi = 0; gi < NSTEP; gi++) begin : g_tab
            logic [DIV_W-1:0]   r_div;
            logic [DWELL_W-1:0] r_dwell;

            // Table entry: reset to the default rate ladder, overwritten by cfg writes.
            always_ff @(posedge clk100) begin
                if (rst) begin
                    r_div   <= DIV_W'(1 << gi);
                    r_dwell <= DWELL_RST;
                end else if (cfg_we_i && (cfg_idx_i == IW'(gi))) begin
                    r_div   <= cfg_div_i;
                    r_dwell <= cfg_dwell_i;
                end
            end

            assign w_tab_div[gi]   = r_div;
            assign w_tab_dwell[gi] = r_dwell;
        end
    endgenerate

    state_t             r_state, w_state_next;
    logic               r_en_q;
    logic               r_oneshot, w_oneshot_next;
    logic [IW-1:0]      r_idx, w_idx_next;
    logic [SW-1:0]      r_skip, w_skip_next;
    logic [DWELL_W-1:0] r_dwell, w_dwell_next;
    logic [PW-1:0]      r_presc, w_presc_next;
    logic [DIV_W-1:0]   r_div, w_div_next;
    logic               r_wren, w_wren_next;
    logic               r_busy, w_busy_next;
    logic               r_done, w_done_next;

    logic               w_start;
    logic               w_last;
    logic [DIV_W-1:0]   w_ent_div;
    logic [DWELL_W-1:0] w_ent_dwell;
    logic [SW-1:0]      w_skip_inc;

    // The table is read with the pre-edge contents, so a write landing on
    // the same edge as a LOAD of that entry is seen only on its next load.
    assign w_start     = en_i & ~r_en_q;
    assign w_last      = (r_idx == IDX_LAST);
    assign w_ent_div   = w_tab_div[r_idx];
    assign w_ent_dwell = w_tab_dwell[r_idx];
    assign w_skip_inc  = r_skip + 1'b1;

    // Next-state and output decode; abort on en_i low overrides everything.
    always_comb begin
        w_state_next   = r_state;
        w_oneshot_next = r_oneshot;
        w_idx_next     = r_idx;
        w_skip_next    = r_skip;
        w_dwell_next   = r_dwell;
        w_presc_next   = r_presc;
        w_div_next     = r_div;
        w_wren_next    = 1'b0;
        w_done_next    = 1'b0;

        if ((r_state != S_IDLE) && !en_i) begin
            w_state_next = S_IDLE;
            w_idx_next   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        w_oneshot_next = oneshot_i;
                        w_idx_next     = '0;
                        w_skip_next    = '0;
                        w_state_next   = S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_ent_dwell != '0) begin
                        w_div_next   = w_ent_div;
                        w_wren_next  = 1'b1;
                        w_dwell_next = w_ent_dwell;
                        w_presc_next = '0;
                        w_skip_next  = '0;
                        w_state_next = S_DWELL;
                    end else begin
                        w_skip_next = w_skip_inc;
                        // A full lap of empty entries ends the pass in either mode.
                        if ((w_skip_inc == SKIP_ALL) || (w_last && r_oneshot)) begin
                            w_done_next  = 1'b1;
                            w_idx_next   = '0;
                            w_state_next = S_IDLE;
                        end else begin
                            w_idx_next   = w_last ? '0 : r_idx + 1'b1;
                            w_state_next = S_LOAD;
                        end
                    end
                end
                S_DWELL: begin
                    if (r_presc == P_LAST) begin
                        w_presc_next = '0;
                        if (r_dwell != '0) begin
                            w_dwell_next = r_dwell - 1'b1;
                        end
                        if (r_dwell == DWELL_W'(1)) begin
                            if (!w_last) begin
                                w_idx_next   = r_idx + 1'b1;
                                w_state_next = S_LOAD;
                            end else if (r_oneshot) begin
                                // One extra cycle so done lands where the next load would.
                                w_state_next = S_FIN;
                            end else begin
                                w_idx_next   = '0;
                                w_state_next = S_LOAD;
                            end
                        end
                    end else begin
                        w_presc_next = r_presc + 1'b1;
                    end
                end
                S_FIN: begin
                    w_done_next  = 1'b1;
                    w_idx_next   = '0;
                    w_state_next = S_IDLE;
                end
                default: begin
                    w_idx_next   = '0;
                    w_state_next = S_IDLE;
                end
            endcase
        end

        w_busy_next = (w_state_next != S_IDLE);
    end

    // Sequencer registers; every output comes straight from one of these.
    always_ff @(posedge clk100) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_en_q    <= 1'b0;
            r_oneshot <= 1'b0;
            r_idx     <= '0;
            r_skip    <= '0;
            r_dwell   <= '0;
            r_presc   <= '0;
            r_div     <= '0;
            r_wren    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_en_q    <= en_i;
            r_oneshot <= w_oneshot_next;
            r_idx     <= w_idx_next;
            r_skip    <= w_skip_next;
            r_dwell   <= w_dwell_next;
            r_presc   <= w_presc_next;
            r_div     <= w_div_next;
            r_wren    <= w_wren_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
        end
    end

    assign div_o  = r_div;
    assign wren_o = r_wren;
    assign step_o = r_idx;
    assign busy_o = r_busy;
    assign done_o = r_done;

endmodule
